// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU I/O bus signals for the UART transmit port.
// The CPU side drives the strobes, address and write data.
// The port side returns the status read data.
`timescale 1ns/1ps
interface uart_tx_port_if;
  logic        uartcs;
  logic        uartwrite;
  logic        uartread;
  logic [1:0]  uartaddr;
  logic [7:0]  uartinputdata;
  logic [15:0] uartoutputdata;

  modport master (
    output uartcs, uartwrite, uartread, uartaddr, uartinputdata,
    input  uartoutputdata
  );

  modport slave (
    input  uartcs, uartwrite, uartread, uartaddr, uartinputdata,
    output uartoutputdata
  );
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter with a small TX FIFO.
// The default frame format is 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit, giving 8E1.
// Address 0 pushes a byte. A write to address 2 clears the sticky overflow flag.
// A read of address 2 returns {5'b0, ovf, busy, full, empty, count[6:0]}.
`timescale 1ns/1ps
module uart_tx_port #(
  parameter int unsigned CLK_HZ     = 23_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clock,
  input  logic           rst_n,
  uart_tx_port_if.slave  bus,
  output logic           tx
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic wr_data_c, wr_ctrl_c, rd_stat_c;
  logic full_c, empty_c, busy_c, push_c, pop_c, baud_end_c;
  logic [7:0] head_c;

  // Bus decode and FIFO flags; fullness uses the pre-pop count
  always_comb begin
    wr_data_c  = bus.uartcs & bus.uartwrite & (bus.uartaddr == 2'd0);
    wr_ctrl_c  = bus.uartcs & bus.uartwrite & (bus.uartaddr == 2'd2);
    rd_stat_c  = bus.uartcs & bus.uartread  & (bus.uartaddr == 2'd2);
    full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c    = (count_q == '0);
    busy_c     = (state_q != S_IDLE);
    push_c     = wr_data_c & ~full_c;
    baud_end_c = (baud_q == BAUD_W'(DIV - 1));
    head_c     = mem_q[rd_ptr_q];
  end

  // Status read path, combinational so data is valid in the read cycle
  assign bus.uartoutputdata = rd_stat_c
    ? {5'b0, ovf_q, busy_c, full_c, empty_c, 7'(count_q)}
    : 16'h0000;

  // Serialiser next state; tx is derived from the next state so it is flopped
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = head_c;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head_c;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = head_c;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head_c;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_ctrl_c) begin
      ovf_d = 1'b0;
    end else if (wr_data_c && full_c) begin
      ovf_d = 1'b1;
    end
  end

  // State registers; reset forces the line idle and empties the FIFO
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage, no reset needed since the pointers define validity
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.uartinputdata;
    end
  end

  assign tx = tx_q;

endmodule
